// File: rtl/tlul_ram_responder.sv
// tlul_ram_responder: TL-UL device that serves Get/PutFullData/PutPartialData
// from a DEPTH x 32b register array through a 2-entry response queue.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   a_valid/a_ready         A-channel handshake (a_ready = queue not full)
//   a_opcode..a_corrupt     A-channel request fields
//   d_valid/d_ready         D-channel handshake
//   d_opcode..d_corrupt     D-channel response fields, driven from the queue head
//
// Optional build macro TLUL_RESPONDER_WAIT_EN: hides each new queue head for
// WAIT_CYCLES cycles before raising d_valid.
module tlul_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SRC_W       = 4,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_param,
    input  logic [2:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [31:0]      a_address,
    input  logic [3:0]       a_mask,
    input  logic [31:0]      a_data,
    input  logic             a_corrupt,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [1:0]       d_param,
    output logic [2:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic             d_sink,
    output logic             d_denied,
    output logic [31:0]      d_data,
    output logic             d_corrupt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // First byte-address bit above the array window.
    localparam int unsigned HI    = IDX_W + 2;

    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd4;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       size;
        logic [SRC_W-1:0] source;
        logic             denied;
        logic [31:0]      data;
        logic             corrupt;
    } rsp_t;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] word_d;

    rsp_t       head_q, head_d;
    rsp_t       tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;

    logic push, pop;
    rsp_t rsp_new;

    // Request decode
    logic             is_get, is_putf, is_putp, is_put;
    logic             op_ok, in_range, param_ok, align_ok, mask_ok, denied;
    logic [3:0]       lanes;
    logic [IDX_W-1:0] idx;
    logic             wr_en;

    assign is_get  = (a_opcode == OP_GET);
    assign is_putf = (a_opcode == OP_PUTF);
    assign is_putp = (a_opcode == OP_PUTP);
    assign is_put  = is_putf | is_putp;
    assign op_ok   = is_get | is_put;

    // BASE_ADDR is DEPTH*4 aligned, so the range test reduces to the
    // address bits above the array window.
    assign in_range = (a_address[31:HI] == BASE_ADDR[31:HI]);
    assign param_ok = (a_param == 3'd0);
    assign idx      = a_address[HI-1:2];

    // Alignment and the exact lane set a PutFull must carry.
    always_comb begin
        align_ok = 1'b0;
        lanes    = 4'b0000;
        case (a_size)
            3'd0: begin
                align_ok = 1'b1;
                lanes    = 4'b0001 << a_address[1:0];
            end
            3'd1: begin
                align_ok = ~a_address[0];
                lanes    = a_address[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                align_ok = (a_address[1:0] == 2'b00);
                lanes    = 4'b1111;
            end
            default: begin
                align_ok = 1'b0;
                lanes    = 4'b0000;
            end
        endcase
    end

    assign mask_ok = ~is_putf | (a_mask == lanes);

    // Out-of-range a_size values fail align_ok, so no separate size test.
    assign denied = ~in_range | ~align_ok | ~param_ok | ~op_ok
                  | ~mask_ok | (is_put & a_corrupt);

    assign a_ready = (cnt_q != 2'd2);
    assign push    = a_valid & a_ready;
    assign pop     = d_valid & d_ready;
    assign wr_en   = push & is_put & ~denied;

    always_comb begin
        rsp_new         = '0;
        rsp_new.opcode  = is_get ? 3'd1 : 3'd0;
        rsp_new.size    = a_size;
        rsp_new.source  = a_source;
        rsp_new.denied  = denied;
        rsp_new.data    = (is_get & ~denied) ? mem_q[idx] : 32'd0;
        rsp_new.corrupt = is_get & denied;
    end

    // Byte-lane merge of write data into the addressed word.
    always_comb begin
        word_d = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) begin
                word_d[8*b +: 8] = a_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= word_d;
        end
    end

    // Two-entry queue: head drives D directly so fields stay stable under
    // back-pressure; a vacated slot is cleared so an idle D bus reads zero.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = rsp_new;
                end else begin
                    tail_d = rsp_new;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                tail_d = '0;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = rsp_new;
                end else begin
                    head_d = rsp_new;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef TLUL_RESPONDER_WAIT_EN
    localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Reload whenever a new entry becomes head: push into an empty queue
    // or any pop (the next entry, if any, starts its own wait).
    always_comb begin
        wait_d = wait_q;
        if (pop || (push && cnt_q == 2'd0)) begin
            wait_d = WAIT_LOAD;
        end else if (cnt_q != 2'd0 && wait_q != '0) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign d_valid = (cnt_q != 2'd0) && (wait_q == '0);
`else
    logic unused_wait;
    assign unused_wait = ^WAIT_CYCLES;
    assign d_valid     = (cnt_q != 2'd0);
`endif

    assign d_opcode  = head_q.opcode;
    assign d_param   = 2'd0;
    assign d_size    = head_q.size;
    assign d_source  = head_q.source;
    assign d_sink    = 1'b0;
    assign d_denied  = head_q.denied;
    assign d_data    = head_q.data;
    assign d_corrupt = head_q.corrupt;

endmodule

// File: tb/tb_tlul_ram_responder.sv
// tb_tlul_ram_responder: directed vector table plus hand sequences for
// back-to-back, back-pressure and mid-queue reset on tlul_ram_responder.
module tb_tlul_ram_responder;

    localparam int SRC_W = 4;
    localparam logic [31:0] B = 32'h2000_0000;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [2:0]       a_opcode = '0;
    logic [2:0]       a_param = '0;
    logic [2:0]       a_size = '0;
    logic [SRC_W-1:0] a_source = '0;
    logic [31:0]      a_address = '0;
    logic [3:0]       a_mask = '0;
    logic [31:0]      a_data = '0;
    logic             a_corrupt = 1'b0;
    logic             d_valid;
    logic             d_ready = 1'b0;
    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_sink;
    logic             d_denied;
    logic [31:0]      d_data;
    logic             d_corrupt;

    int checks = 0;
    int failures = 0;

    tlul_ram_responder #(
        .BASE_ADDR(B), .DEPTH(16), .SRC_W(SRC_W), .WAIT_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
        .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  prm;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        cor;
        logic [2:0]  e_op;
        logic        e_den;
        logic [31:0] e_data;
        logic        e_cor;
    } vec_t;

    vec_t tv [22];

    function automatic vec_t mk(
        input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
        input logic [31:0] addr, input logic [3:0] mask,
        input logic [31:0] data, input logic cor,
        input logic [2:0] e_op, input logic e_den,
        input logic [31:0] e_data, input logic e_cor);
        vec_t v;
        v.op = op; v.prm = prm; v.sz = sz; v.addr = addr; v.mask = mask;
        v.data = data; v.cor = cor; v.e_op = e_op; v.e_den = e_den;
        v.e_data = e_data; v.e_cor = e_cor;
        return v;
    endfunction

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Single request with d_ready=1; entered and left at posedge+1.
    task automatic send(input int id, input vec_t v, input logic [SRC_W-1:0] src);
        int n;
        a_opcode = v.op; a_param = v.prm; a_size = v.sz; a_source = src;
        a_address = v.addr; a_mask = v.mask; a_data = v.data;
        a_corrupt = v.cor; a_valid = 1'b1; d_ready = 1'b1;
        n = 0;
        while (!a_ready && n < 10) begin
            @(posedge clock); #1; n++;
        end
        if (n == 10) begin
            checks++; failures++;
            $display("FAIL a_ready_timeout vec=%0d got=0 want=1", id);
        end
        @(posedge clock); #1;
        a_valid = 1'b0;
        check($sformatf("vec%0d_valid", id), 128'(d_valid), 128'(1'b1));
        check($sformatf("vec%0d_rsp", id),
              128'({d_opcode, d_param, d_size, d_source, d_sink,
                    d_denied, d_data, d_corrupt}),
              128'({v.e_op, 2'b00, v.sz, src, 1'b0,
                    v.e_den, v.e_data, v.e_cor}));
        @(posedge clock); #1;
        check($sformatf("vec%0d_drain", id), 128'(d_valid), 128'(1'b0));
    endtask

    initial begin
        // op prm sz addr mask data cor | e_op e_den e_data e_cor
        tv[0]  = mk(0,0,2,B+'h08,4'hF,32'hDEADBEEF,0, 0,0,0,0);
        tv[1]  = mk(4,0,2,B+'h08,4'hF,0,0,           1,0,32'hDEADBEEF,0);
        tv[2]  = mk(1,0,2,B+'h08,4'b0101,32'h11223344,0, 0,0,0,0);
        tv[3]  = mk(4,0,2,B+'h08,4'hF,0,0,           1,0,32'hDE22BE44,0);
        tv[4]  = mk(4,0,2,B+'h40,4'hF,0,0,           1,1,0,1);
        tv[5]  = mk(4,0,3,B+'h08,4'hF,0,0,           1,1,0,1);
        tv[6]  = mk(0,0,2,B+'h08,4'b0111,32'h0,0,    0,1,0,0);
        tv[7]  = mk(4,0,2,B+'h08,4'hF,0,0,           1,0,32'hDE22BE44,0);
        tv[8]  = mk(4,0,2,B-'h4,4'hF,0,0,            1,1,0,1);
        tv[9]  = mk(4,0,2,B+'h0A,4'hF,0,0,           1,1,0,1);
        tv[10] = mk(0,0,0,B+'h0D,4'b0010,32'h0000AB00,0, 0,0,0,0);
        tv[11] = mk(0,0,1,B+'h0E,4'b1100,32'h12340000,0, 0,0,0,0);
        tv[12] = mk(4,0,0,B+'h0F,4'b1000,0,0,        1,0,32'h1234AB00,0);
        tv[13] = mk(2,0,2,B+'h0C,4'hF,0,0,           0,1,0,0);
        tv[14] = mk(0,0,2,B+'h0C,4'hF,32'hFFFFFFFF,1, 0,1,0,0);
        tv[15] = mk(4,1,2,B+'h0C,4'hF,0,0,           1,1,0,1);
        tv[16] = mk(1,0,2,B+'h10,4'b0000,32'hFFFFFFFF,0, 0,0,0,0);
        tv[17] = mk(4,0,2,B+'h10,4'hF,0,0,           1,0,32'h0,0);
        tv[18] = mk(0,0,1,B+'h11,4'b0110,32'hFFFFFFFF,0, 0,1,0,0);
        tv[19] = mk(4,0,2,B+'h0C,4'hF,0,0,           1,0,32'h1234AB00,0);
        tv[20] = mk(0,0,0,B+'h3F,4'b1000,32'h77000000,0, 0,0,0,0);
        tv[21] = mk(4,0,2,B+'h3C,4'hF,0,0,           1,0,32'h77000000,0);

        repeat (2) @(posedge clock);
        #1;
        check("reset_state",
              128'({d_valid, a_ready, d_opcode, d_size, d_source,
                    d_denied, d_data, d_corrupt}),
              128'({1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 32'd0, 1'b0}));
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            send(i, tv[i], SRC_W'(i));
        end

        // Eight back-to-back Gets with d_ready held high.
        a_opcode = 3'd4; a_param = 0; a_size = 3'd2; a_address = B + 'h08;
        a_mask = 4'hF; a_corrupt = 0; d_ready = 1'b1; a_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a_source = SRC_W'(k);
            check($sformatf("b2b%0d_ready", k), 128'(a_ready), 128'(1'b1));
            @(posedge clock); #1;
            check($sformatf("b2b%0d_rsp", k),
                  128'({d_valid, d_source, d_data}),
                  128'({1'b1, 4'(k), 32'hDE22BE44}));
        end
        a_valid = 1'b0;
        @(posedge clock); #1;
        check("b2b_drain", 128'(d_valid), 128'(1'b0));

        // Back-pressure: 5 edges with d_ready low, queue fills at 2.
        d_ready = 1'b0; a_valid = 1'b1; a_source = 4'd10;
        @(posedge clock); #1;
        a_source = 4'd11;
        @(posedge clock); #1;
        a_source = 4'd12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_stall", k),
                  128'({a_ready, d_valid, d_source, d_opcode, d_data}),
                  128'({1'b0, 1'b1, 4'd10, 3'd1, 32'hDE22BE44}));
            @(posedge clock); #1;
        end
        check("bp_stall_end",
              128'({a_ready, d_valid, d_source}),
              128'({1'b0, 1'b1, 4'd10}));
        a_valid = 1'b0; d_ready = 1'b1;
        #1;
        check("bp_no_comb_ready", 128'(a_ready), 128'(1'b0));
        @(posedge clock); #1;
        check("bp_drain1",
              128'({a_ready, d_valid, d_source}),
              128'({1'b1, 1'b1, 4'd11}));
        @(posedge clock); #1;
        check("bp_drain2", 128'(d_valid), 128'(1'b0));

        // Reset with two responses queued.
        d_ready = 1'b0; a_valid = 1'b1; a_source = 4'd1;
        @(posedge clock); #1;
        a_source = 4'd2;
        @(posedge clock); #1;
        a_valid = 1'b0;
        check("rst_full", 128'(a_ready), 128'(1'b0));
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_flush",
              128'({d_valid, a_ready, d_data}),
              128'({1'b0, 1'b1, 32'd0}));
        reset = 1'b1;
        send(100, mk(4,0,2,B+'h08,4'hF,0,0, 1,0,32'h0,0), 4'd3);
        send(101, mk(4,0,2,B+'h0C,4'hF,0,0, 1,0,32'h0,0), 4'd4);
        send(102, mk(4,0,2,B+'h3C,4'hF,0,0, 1,0,32'h0,0), 4'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
